// File: rtl/inst_encoder_pkg.sv
// Shared miniRV encoder definitions: symbolic op codes, RV32I opcode/funct
// constants and per-format instruction packing helpers.
package inst_encoder_pkg;

    typedef enum logic [4:0] {
        OP_ADD  = 5'd0,  OP_SUB  = 5'd1,  OP_AND  = 5'd2,  OP_OR   = 5'd3,
        OP_XOR  = 5'd4,  OP_SLL  = 5'd5,  OP_SRL  = 5'd6,  OP_SRA  = 5'd7,
        OP_ADDI = 5'd8,  OP_ANDI = 5'd9,  OP_ORI  = 5'd10, OP_XORI = 5'd11,
        OP_SLLI = 5'd12, OP_SRLI = 5'd13, OP_SRAI = 5'd14, OP_LW   = 5'd15,
        OP_SW   = 5'd16, OP_BEQ  = 5'd17, OP_BNE  = 5'd18, OP_BLT  = 5'd19,
        OP_BGE  = 5'd20, OP_LUI  = 5'd21, OP_JAL  = 5'd22, OP_JALR = 5'd23
    } op_e;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_I    = 7'b0010011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_S    = 7'b0100011;
    localparam logic [6:0] OPC_B    = 7'b1100011;
    localparam logic [6:0] OPC_LUI  = 7'b0110111;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_W    = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_JALR = 3'b000;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, OPC_R};
    endfunction

    // Shift-immediates reuse this by passing {funct7, shamt} as imm12.
    function automatic logic [31:0] enc_i(input logic [11:0] imm12, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm12, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm12, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm12[11:5], rs2, rs1, f3, imm12[4:0], OPC_S};
    endfunction

    // off holds byte-offset bits [12:1]; bit 0 of the offset is never encoded.
    function automatic logic [31:0] enc_b(input logic [11:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[11], off[9:4], rs2, rs1, f3, off[3:0], off[10], OPC_B};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] imm20, input logic [4:0] rd);
        return {imm20, rd, OPC_LUI};
    endfunction

    // off holds byte-offset bits [20:1].
    function automatic logic [31:0] enc_j(input logic [19:0] off, input logic [4:0] rd);
        return {off[19], off[9:0], off[10], off[18:11], rd, OPC_JAL};
    endfunction

endpackage

// File: rtl/inst_encoder_if.sv
// Request and IROM write-port bundle between a program builder and the encoder.
interface inst_encoder_if #(
    parameter int ADDR_W = 14
) ();
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_op;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [31:0]       in_imm;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              mem_ready;

    modport master (
        output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        input  in_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, mem_ready,
        output in_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/inst_encoder_sync_fifo.sv
// Single-clock FIFO with occupancy count; head reads as zero while empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_din,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_dout,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_dout  = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/inst_encoder.sv
// Encodes symbolic miniRV requests into RV32I words, buffers them and streams
// them into IROM at consecutive word addresses starting from base_addr.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    inst_encoder_if.slave          bus,
    output logic [$clog2(DEPTH):0] level,
    output logic                   err,
    output logic [7:0]             err_cnt,
    output logic                   wrapped
);
    logic [31:0]            w_word;
    logic                   w_legal;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_empty;
    logic [31:0]            w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_start_ok;
    logic                   w_illegal;

    logic [ADDR_W-1:0]      r_addr;
    logic                   r_wrapped;
    logic                   r_err;
    logic [7:0]             r_err_cnt;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        w_word  = '0;
        w_legal = 1'b1;
        case (bus.in_op)
            OP_ADD:  w_word = enc_r(F7_BASE, bus.in_rs2, bus.in_rs1, F3_ADD, bus.in_rd);
            OP_SUB:  w_word = enc_r(F7_ALT,  bus.in_rs2, bus.in_rs1, F3_ADD, bus.in_rd);
            OP_AND:  w_word = enc_r(F7_BASE, bus.in_rs2, bus.in_rs1, F3_AND, bus.in_rd);
            OP_OR:   w_word = enc_r(F7_BASE, bus.in_rs2, bus.in_rs1, F3_OR,  bus.in_rd);
            OP_XOR:  w_word = enc_r(F7_BASE, bus.in_rs2, bus.in_rs1, F3_XOR, bus.in_rd);
            OP_SLL:  w_word = enc_r(F7_BASE, bus.in_rs2, bus.in_rs1, F3_SLL, bus.in_rd);
            OP_SRL:  w_word = enc_r(F7_BASE, bus.in_rs2, bus.in_rs1, F3_SR,  bus.in_rd);
            OP_SRA:  w_word = enc_r(F7_ALT,  bus.in_rs2, bus.in_rs1, F3_SR,  bus.in_rd);
            OP_ADDI: w_word = enc_i(bus.in_imm[11:0], bus.in_rs1, F3_ADD, bus.in_rd, OPC_I);
            OP_ANDI: w_word = enc_i(bus.in_imm[11:0], bus.in_rs1, F3_AND, bus.in_rd, OPC_I);
            OP_ORI:  w_word = enc_i(bus.in_imm[11:0], bus.in_rs1, F3_OR,  bus.in_rd, OPC_I);
            OP_XORI: w_word = enc_i(bus.in_imm[11:0], bus.in_rs1, F3_XOR, bus.in_rd, OPC_I);
            OP_SLLI: w_word = enc_i({F7_BASE, bus.in_imm[4:0]}, bus.in_rs1, F3_SLL, bus.in_rd, OPC_I);
            OP_SRLI: w_word = enc_i({F7_BASE, bus.in_imm[4:0]}, bus.in_rs1, F3_SR,  bus.in_rd, OPC_I);
            OP_SRAI: w_word = enc_i({F7_ALT,  bus.in_imm[4:0]}, bus.in_rs1, F3_SR,  bus.in_rd, OPC_I);
            OP_LW:   w_word = enc_i(bus.in_imm[11:0], bus.in_rs1, F3_W, bus.in_rd, OPC_LW);
            OP_SW:   w_word = enc_s(bus.in_imm[11:0], bus.in_rs2, bus.in_rs1, F3_W);
            OP_BEQ:  w_word = enc_b(bus.in_imm[12:1], bus.in_rs2, bus.in_rs1, F3_BEQ);
            OP_BNE:  w_word = enc_b(bus.in_imm[12:1], bus.in_rs2, bus.in_rs1, F3_BNE);
            OP_BLT:  w_word = enc_b(bus.in_imm[12:1], bus.in_rs2, bus.in_rs1, F3_BLT);
            OP_BGE:  w_word = enc_b(bus.in_imm[12:1], bus.in_rs2, bus.in_rs1, F3_BGE);
            OP_LUI:  w_word = enc_u(bus.in_imm[31:12], bus.in_rd);
            OP_JAL:  w_word = enc_j(bus.in_imm[20:1], bus.in_rd);
            OP_JALR: w_word = enc_i(bus.in_imm[11:0], bus.in_rs1, F3_JALR, bus.in_rd, OPC_JALR);
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal ops are still handshaken so a bad request never stalls the stream.
    assign w_accept   = bus.in_valid & bus.in_ready;
    assign w_push     = w_accept & w_legal;
    assign w_illegal  = w_accept & ~w_legal;
    assign w_pop      = bus.wr_en & bus.mem_ready;
    assign w_start_ok = start & (w_count == '0);

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   (w_word),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.in_ready = ~w_full;
    assign bus.wr_en    = ~w_empty;
    assign bus.wr_data  = w_head;
    assign bus.wr_addr  = r_addr;
    assign level        = w_count;
    assign err          = r_err;
    assign err_cnt      = r_err_cnt;
    assign wrapped      = r_wrapped;

    // A honoured start implies an empty FIFO, so it never races a pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wrapped <= 1'b0;
        end else if (w_start_ok) begin
            r_addr    <= base_addr;
            r_wrapped <= 1'b0;
        end else if (w_pop) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_addr == '1) r_wrapped <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_illegal;
            if (w_start_ok)
                r_err_cnt <= w_illegal ? 8'd1 : 8'd0;
            else if (w_illegal)
                r_err_cnt <= sat_inc(r_err_cnt);
        end
    end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Assembles symbolic miniRV operations into 32-bit RV32I instruction words and streams them into the instruction ROM's write port. It is the encoding counterpart of the core's instruction-decode stage. Self-test and boot sequencing logic use it to build programs in IROM without a host toolchain. Requests enter through a valid/ready handshake, are encoded in the accept cycle, are buffered in a small FIFO, and drain to memory at up to one word per cycle under memory backpressure.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `ADDR_W`, 14: IROM word-address width.
- `clk` input 1: single clock, all state on rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: pulse; loads `base_addr` into the write-address counter.
- `base_addr` input ADDR_W: first word address of the program.
- `in_valid` input 1: request valid.
- `in_ready` output 1: request can be taken; equals `~full`.
- `in_op` input 5: operation code, defined in the shared header: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 ADDI, 9 ANDI, 10 ORI, 11 XORI, 12 SLLI, 13 SRLI, 14 SRAI, 15 LW, 16 SW, 17 BEQ, 18 BNE, 19 BLT, 20 BGE, 21 LUI, 22 JAL, 23 JALR, 24–31 illegal.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register fields.
- `in_imm` input 32: immediate, given as the architectural value. LUI uses bits [31:12]. Branch and JAL use the byte offset, and bit 0 is dropped.
- `wr_en` output 1: IROM write request (FIFO non-empty).
- `wr_addr` output ADDR_W: word address.
- `wr_data` output 32: encoded instruction (FIFO head).
- `mem_ready` input 1: the write completes in any cycle where `wr_en & mem_ready`.
- `level` output $clog2(DEPTH)+1: FIFO occupancy.
- `err` output 1: one-cycle pulse when an illegal op is handshaken.
- `err_cnt` output 8: saturating count of illegal ops.
- `wrapped` output 1: sticky; set when the address counter rolls from all-ones to 0.

## Operation
- **Accept:** a request is taken when `in_valid & in_ready`.
  - A legal op is encoded combinationally and pushed into the FIFO.
  - An illegal op is consumed without a push. It pulses `err` in the following cycle and increments `err_cnt`, which saturates at 255.
- **Encoding by format:**
  - R-type: `funct7` is 0x20 for SUB and SRA, 0 otherwise.
  - I-type: imm[11:0]. SLLI, SRLI and SRAI use shamt = imm[4:0], with `funct7` 0x20 only for SRAI.
  - Fields ignored by a format (for example `rs2` on I-type, `rd` on S/B) do not affect the output word.
  - Out-of-range immediates are truncated without any error.
- **Drain:** the FIFO head is presented on `wr_data` with `wr_addr` = the counter value.
  - On each completed write the FIFO pops and the counter increments modulo 2^ADDR_W.
  - A completed write at address 2^ADDR_W−1 sets `wrapped`.
- **`start`:** honoured only when the FIFO is empty (`level`=0).
  - Otherwise it is ignored, and the counter and FIFO are unchanged.
  - An honoured `start` also clears `wrapped` and `err_cnt`.
- **Push and pop together:** when full, a pop and a push cannot coincide, because `in_ready` depends only on `full`. When partially full, a simultaneous push and pop leave `level` unchanged.
- **Reset values:** the asynchronous reset forces `in_ready`=1, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `level`=0, `err`=0, `err_cnt`=0, `wrapped`=0. All buffered entries are discarded. A reset during draining aborts the drain, and no further writes are issued.

## Timing
- Request accepted in cycle N → `wr_en`=1 with that word in cycle N+1, if the FIFO was empty.
- Sustained throughput is 1 word per cycle while `mem_ready`=1.
- `in_ready` falls in the cycle after the push that fills the FIFO.
- `in_ready` rises in the cycle after the pop from full.
- `err` goes high in cycle N+1 for an illegal op accepted in cycle N.
- An honoured `start` in cycle S gives `wr_addr`=`base_addr` from cycle S+1.
- `wr_addr`, `wr_data` and `wr_en` hold stable while `mem_ready`=0.

## Structure
- The shared defines header holds:
  - the op-code constants;
  - the RV32I opcode constants (R, I, LW, S, B, U/LUI, J/JAL, JALR);
  - the funct3 and funct7 constants.
- One sub-module, `sync_fifo` (DEPTH × 32, with full, empty and count), is instantiated once. The encoder case logic and the address counter stay in `inst_encoder`.

## Test plan
- **Basic encode and address:** after reset, `start` with `base_addr`=0x100, `mem_ready`=1, then ADDI rd=1 rs1=0 imm=5. The bench must see a write of 0x00500093 at 0x100 in the cycle after the handshake.
- **Back-to-back stream:** ADD(3,1,2), SUB(3,1,2), LUI(5, 0x12345000), SW(rs1=1, rs2=2, imm=12). Required writes: 0x002081B3, 0x402081B3, 0x123452B7, 0x0020A623 at consecutive addresses.
- **Control flow:** BEQ(rs1=1, rs2=2, imm=8) → 0x00208463. JAL(rd=1, imm=16) → 0x010000EF.
- **Backpressure:** hold `mem_ready`=0 and offer 6 requests.
  - `in_ready` drops after 4 accepted and `level`=4, with outputs stable.
  - Release `mem_ready`: all 6 words are written in order with no loss or duplication.
- **Illegal op:** in_op=27 → `err` pulses once, `err_cnt`=1, no write, address unchanged. The next legal op is written at the expected address.
- **Wrap, `start` and reset:**
  - Use `ADDR_W`=4 and `base_addr`=15. The two writes go to 15 then 0, and `wrapped`=1.
  - `start` while `level`>0 is ignored.
  - Asserting `rst_n`=0 mid-stream drops `wr_en` immediately and resets `level` to 0.
